frac_cen_gen: RTL
=================

# frac_cen_gen

Multi-channel fractional clock-enable generator for the simulation and FPGA tops. It replaces fixed divide-by-N enable taps with per-channel runtime-programmable ratios `num/den` of `clk_sys`. A test harness can therefore switch pixel, CPU and audio enables between fast-simulation and accurate rates without editing RTL. All outputs are single-cycle, registered `cen` pulses in the `clk_sys` domain.

## Interface
- `CHANNELS`, default 4: number of independent enable outputs (1..16).
- `W`, default 16: width of the ratio terms and accumulators.
- `RESET_DEN`, default 4: denominator loaded into every channel at reset; numerator resets to 1.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: global enable. When low, accumulators hold and all `cen` are 0.
- `resync` in 1: one-cycle pulse that phase-aligns all channels.
- `cfg_wr` in 1: writes `cfg_num`/`cfg_den` to the shadow registers of channel `cfg_ch`.
- `cfg_ch` in $clog2(CHANNELS), minimum 1: target channel; values ≥ CHANNELS are ignored.
- `cfg_num` in W: new numerator.
- `cfg_den` in W: new denominator.
- `cfg_pending` out CHANNELS: bit i is high while channel i holds an unapplied shadow config.
- `cen` out CHANNELS: enable pulses.

## Operation
- Per channel, the active registers are `num` and `den`, and the phase register is `acc` (W bits).
- Effective numerator `n_eff = min(num, den)`.
- Each cycle with `run`=1 and `den`≠0, compute `sum = acc + n_eff` at W+1 bits.
  - If `sum ≥ den`: `cen`=1 and `acc` ← `sum − den`.
  - Otherwise: `cen`=0 and `acc` ← `sum`.
- Long-run rate is exactly `n_eff/den` pulses per cycle. No cumulative drift.
- Disabled channel: `den`=0 or `num`=0 gives `cen`=0 and `acc` held at 0.
- Config shadow:
  - `cfg_wr` loads the shadow and sets `cfg_pending[ch]`.
  - A second write while pending overwrites the shadow.
- Config apply: the shadow moves to active on the edge where the channel emits `cen`, or on the next edge if the channel is disabled. `cfg_pending` clears on that same edge.
- Residual phase on apply: if `sum − den_old` ≥ the new `den`, `acc` ← 0; otherwise the remainder is kept.
- Pulse shape on apply: the ratio changes without a runt or doubled pulse. The new ratio governs from the following cycle.
- `resync`:
  - On the next edge, all `acc` ← 0 and all pending configs are applied immediately.
  - `cen` is 0 on that cycle.
  - `resync` takes priority over pulse generation and the normal apply.
  - `cfg_wr` in the same cycle lands in the shadow first, so it is applied by that `resync`.
- `run`=0 does not block `cfg_wr`, but the apply waits for a pulse or `resync`. Disabled channels still apply on the next edge.

## Timing
- Reset (async assert): `cen`=0, `cfg_pending`=0, `acc`=0, `num`=1, `den`=RESET_DEN. Deassertion is synchronous to `clk_sys` in the top.
- With `num`/`den` = 1/`RESET_DEN`, the first `cen` occurs on the `RESET_DEN`-th edge after reset release with `run`=1.
- `cen` is registered: the accumulator decision at edge k appears on `cen` after edge k.
- `cfg_pending` rises one edge after `cfg_wr`.
- Back-to-back pulses are allowed: `n_eff`=`den` gives `cen` high every cycle.
- Arithmetic: one W+1-bit adder and one W+1-bit compare/subtract per channel. No division. Must close at 96 MHz with W=16.

## Structure
- Package `cen_pkg`:
  - `CEN_W` default.
  - `cen_cfg_t` struct {num, den}.
  - Named ratio constants `CEN_48M_TO_12M` (1/4) and `CEN_48M_TO_4M` (1/12).
- Sub-module `frac_cen_ch`: one channel (accumulator, shadow, pending, apply logic).
- The top instantiates `CHANNELS` copies with a generate loop, decodes `cfg_ch`, and fans out `run`/`resync`.

## Test plan
- Reset, then `run`=1, defaults (1/4) → each `cen` pulses exactly every 4th cycle, first pulse 4 edges after release.
- Channel 0 set to 3/8 then `resync` → exactly 3 pulses in every 8-cycle window, pattern 00100101 repeating. Channel 1 set to 1/12 → 1 pulse per 12 cycles.
- Mid-period reconfig of ch0 from 1/4 to 1/2 (write 1 cycle after a pulse) → `cfg_pending[0]` high for 3 cycles, no extra pulse, then pulses every 2 cycles.
- `cfg_num`=5, `cfg_den`=3 → `cen` high every cycle. Then `den`=0 → `cen` stays 0 and `cfg_pending` clears 1 edge after the write.
- `resync` plus `cfg_wr` in the same cycle → new ratio active, all `acc`=0, all `cen`=0 that cycle, channels pulse in phase afterwards.
- `reset` asserted mid-run with configs pending → `cen` and `cfg_pending` drop immediately (asynchronously), and defaults are restored after release.

Source files
------------

// File: rtl/cen_pkg.sv
// Shared widths, config record and common ratio constants for the
// fractional clock-enable generator.
package cen_pkg;

  localparam int CEN_W = 16;

  typedef struct packed {
    logic [CEN_W-1:0] num;
    logic [CEN_W-1:0] den;
  } cen_cfg_t;

  localparam cen_cfg_t CEN_48M_TO_12M = '{num: CEN_W'(1), den: CEN_W'(4)};
  localparam cen_cfg_t CEN_48M_TO_4M  = '{num: CEN_W'(1), den: CEN_W'(12)};

endpackage

// File: rtl/frac_cen_ch.sv
// One fractional enable channel: phase accumulator, shadow config with
// pending flag, and pulse-synchronous config apply.
module frac_cen_ch
  import cen_pkg::*;
#(
  parameter int W         = CEN_W,
  parameter int RESET_DEN = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         run,
  input  logic         resync,
  input  logic         cfg_wr,
  input  logic [W-1:0] cfg_num,
  input  logic [W-1:0] cfg_den,
  output logic         cfg_pending,
  output logic         cen
);

  logic [W-1:0] num_q, num_d, den_q, den_d, acc_q, acc_d;
  logic [W-1:0] shd_num_q, shd_num_d, shd_den_q, shd_den_d;
  logic         pend_q, pend_d, cen_q, cen_d;

  logic [W-1:0] n_eff, rem;
  logic [W:0]   sum;
  logic         off, hit, apply;

  always_comb begin
    n_eff = (num_q < den_q) ? num_q : den_q;
    off   = (num_q == '0) || (den_q == '0);
    sum   = {1'b0, acc_q} + {1'b0, n_eff};
    hit   = !off && (sum >= {1'b0, den_q});
    // acc < den always holds, so the remainder fits back into W bits
    rem   = hit ? W'(sum - {1'b0, den_q}) : W'(sum);
  end

  always_comb begin
    num_d     = num_q;
    den_d     = den_q;
    acc_d     = acc_q;
    cen_d     = 1'b0;
    apply     = 1'b0;
    shd_num_d = cfg_wr ? cfg_num : shd_num_q;
    shd_den_d = cfg_wr ? cfg_den : shd_den_q;
    if (resync) begin
      acc_d = '0;
      apply = pend_q || cfg_wr;
      if (apply) begin
        num_d = shd_num_d;
        den_d = shd_den_d;
      end
    end else if (off) begin
      acc_d = '0;
      apply = pend_q;
      if (apply) begin
        num_d = shd_num_q;
        den_d = shd_den_q;
      end
    end else if (run) begin
      cen_d = hit;
      acc_d = rem;
      apply = hit && pend_q;
      if (apply) begin
        num_d = shd_num_q;
        den_d = shd_den_q;
        if (rem >= shd_den_q) acc_d = '0;
      end
    end
    pend_d = resync ? 1'b0 : (cfg_wr || (pend_q && !apply));
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      num_q     <= W'(1);
      den_q     <= W'(RESET_DEN);
      acc_q     <= '0;
      shd_num_q <= W'(1);
      shd_den_q <= W'(RESET_DEN);
      pend_q    <= 1'b0;
      cen_q     <= 1'b0;
    end else begin
      num_q     <= num_d;
      den_q     <= den_d;
      acc_q     <= acc_d;
      shd_num_q <= shd_num_d;
      shd_den_q <= shd_den_d;
      pend_q    <= pend_d;
      cen_q     <= cen_d;
    end
  end

  assign cfg_pending = pend_q;
  assign cen         = cen_q;

endmodule

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator: decodes config writes
// to per-channel shadows and fans out run/resync to every channel.
module frac_cen_gen
  import cen_pkg::*;
#(
  parameter int  CHANNELS  = 4,
  parameter int  W         = CEN_W,
  parameter int  RESET_DEN = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                run,
  input  logic                resync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [W-1:0]        cfg_num,
  input  logic [W-1:0]        cfg_den,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] cen
);

  logic [CHANNELS-1:0] wr_sel;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // out-of-range channel indices never match any decode
    assign wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));

    frac_cen_ch #(
      .W         (W),
      .RESET_DEN (RESET_DEN)
    ) u_ch (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .run         (run),
      .resync      (resync),
      .cfg_wr      (wr_sel[i]),
      .cfg_num     (cfg_num),
      .cfg_den     (cfg_den),
      .cfg_pending (cfg_pending[i]),
      .cen         (cen[i])
    );
  end

endmodule
